serial_add_sub: RTL and testbench

//   Parametrised bit-serial adder/subtractor, the sequential successor of the

---
 rtl/serial_add_sub.sv | 88 ++++++++
 tb/tb_serial_add_sub.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder slice plus a carry flip-flop.
// It processes the operands LSB-first, one bit per clock.
module serial_add_sub #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // Handshake: start is accepted only while busy=0, and the accepting edge
  // also samples a, b and sub. Requests made while busy are dropped. done
  // pulses for one cycle after the result registers settle, and sum, cout
  // and ovf then hold until the next accepted start.
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             c;
  logic [CNT_W-1:0] cnt;
  logic             s_bit;
  logic             c_next;
  logic             p_bit;

  // Full-adder slice built from xor/and gates.
  assign p_bit  = sh_a[0] ^ sh_b[0];
  assign s_bit  = p_bit ^ c;
  assign c_next = (sh_a[0] & sh_b[0]) | (p_bit & c);

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh_a  <= '0;
      sh_b  <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a  <= a;
            sh_b  <= sub ? ~b : b;
            c     <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum  <= {s_bit, sum[WIDTH-1:1]};
          sh_a <= sh_a >> 1;
          sh_b <= sh_b >> 1;
          c    <= c_next;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            // Overflow is the carry into the MSB differing from the carry out.
            ovf   <= c ^ c_next;
            cout  <= c_next;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub, with 4-bit and 8-bit instances sharing one clock.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start4 = 1'b0, sub4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0, sum4;
  logic       cout4, ovf4, busy4, done4;

  logic       start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cout8, ovf8, busy8, done8;

  int passed = 0;
  int total  = 0;

  serial_add_sub #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .a(a4), .b(b4),
    .sum(sum4), .cout(cout4), .ovf(ovf4), .busy(busy4), .done(done4)
  );

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .sum(sum8), .cout(cout8), .ovf(ovf8), .busy(busy8), .done(done8)
  );

  // Launch one 4-bit op and wait for done; lat counts edges after the start edge.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic ts, output int lat);
    @(negedge clk);
    a4 = ta; b4 = tb; sub4 = ts; start4 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start4 = 1'b0;
    while (!done4 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, output int lat);
    @(negedge clk);
    a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    start8 = 1'b0;
    while (!done8 && lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({sum4, cout4, ovf4, busy4, done4} !== 8'h00)
      $display("FAIL reset_w4 got %h want 00", {sum4, cout4, ovf4, busy4, done4});
    else passed++;
    total++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000)
      $display("FAIL reset_w8 got %h want 000", {sum8, cout8, ovf8, busy8, done8});
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy4 !== 1'b0 || done4 !== 1'b0)
      $display("FAIL idle_after_reset busy=%b done=%b want 0 0", busy4, done4);
    else passed++;
  endtask

  task automatic test_add();
    int lat;
    op4(4'd3, 4'd5, 1'b0, lat);
    total++;
    if (lat !== 5) $display("FAIL add_3_5_latency got %0d want 5", lat); else passed++;
    total++;
    if ({sum4, cout4, ovf4} !== {4'd8, 1'b0, 1'b1})
      $display("FAIL add_3_5 got sum=%0d c=%b v=%b want 8 0 1", sum4, cout4, ovf4);
    else passed++;
    @(negedge clk);
    total++;
    if (done4 !== 1'b0) $display("FAIL done_one_cycle got %b want 0", done4); else passed++;
    total++;
    if (sum4 !== 4'd8) $display("FAIL sum_hold got %0d want 8", sum4); else passed++;

    op4(4'd15, 4'd1, 1'b0, lat);
    total++;
    if ({sum4, cout4, ovf4} !== {4'd0, 1'b1, 1'b0} || lat !== 5)
      $display("FAIL add_15_1 got sum=%0d c=%b v=%b lat=%0d want 0 1 0 5", sum4, cout4, ovf4, lat);
    else passed++;
    op4(4'd0, 4'd0, 1'b0, lat);
    total++;
    if ({sum4, cout4, ovf4} !== {4'd0, 1'b0, 1'b0} || lat !== 5)
      $display("FAIL add_0_0 got sum=%0d c=%b v=%b lat=%0d want 0 0 0 5", sum4, cout4, ovf4, lat);
    else passed++;
  endtask

  task automatic test_sub();
    int lat;
    op4(4'd5, 4'd3, 1'b1, lat);
    total++;
    if ({sum4, cout4, ovf4} !== {4'd2, 1'b1, 1'b0} || lat !== 5)
      $display("FAIL sub_5_3 got sum=%0d c=%b v=%b lat=%0d want 2 1 0 5", sum4, cout4, ovf4, lat);
    else passed++;
    op4(4'd3, 4'd5, 1'b1, lat);
    total++;
    if ({sum4, cout4, ovf4} !== {4'd14, 1'b0, 1'b0} || lat !== 5)
      $display("FAIL sub_3_5 got sum=%0d c=%b v=%b lat=%0d want 14 0 0 5", sum4, cout4, ovf4, lat);
    else passed++;
    op4(4'd8, 4'd1, 1'b1, lat);
    total++;
    if ({sum4, cout4, ovf4} !== {4'd7, 1'b1, 1'b1} || lat !== 5)
      $display("FAIL sub_8_1 got sum=%0d c=%b v=%b lat=%0d want 7 1 1 5", sum4, cout4, ovf4, lat);
    else passed++;
  endtask

  // start is held high the whole time; operand changes while busy must be ignored.
  task automatic test_back_to_back();
    int lat;
    int gap;
    @(negedge clk);
    a4 = 4'd1; b4 = 4'd1; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    a4 = 4'd7; b4 = 4'd7;
    while (!done4 && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    total++;
    if ({sum4, cout4, ovf4} !== {4'd2, 1'b0, 1'b0} || lat !== 5)
      $display("FAIL held_start_first got sum=%0d c=%b v=%b lat=%0d want 2 0 0 5", sum4, cout4, ovf4, lat);
    else passed++;
    total++;
    if (busy4 !== 1'b0) $display("FAIL busy_in_done_cycle got %b want 0", busy4); else passed++;
    gap = 0;
    @(posedge clk);
    gap++;
    @(negedge clk);
    total++;
    if (busy4 !== 1'b1) $display("FAIL second_op_accepted busy got %b want 1", busy4); else passed++;
    while (!done4 && gap < 20) begin
      @(posedge clk);
      gap++;
      @(negedge clk);
    end
    start4 = 1'b0;
    total++;
    if (gap !== 6) $display("FAIL done_spacing got %0d want 6", gap); else passed++;
    total++;
    if ({sum4, cout4, ovf4} !== {4'd14, 1'b0, 1'b1})
      $display("FAIL held_start_second got sum=%0d c=%b v=%b want 14 0 1", sum4, cout4, ovf4);
    else passed++;
  endtask

  task automatic test_async_reset();
    int lat;
    int seen;
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd4; sub4 = 1'b0; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({sum4, cout4, ovf4, busy4, done4} !== 8'h00)
      $display("FAIL async_reset_outputs got %h want 00", {sum4, cout4, ovf4, busy4, done4});
    else passed++;
    #10;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done4 === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) $display("FAIL no_done_after_abort got %0d pulses want 0", seen); else passed++;
    op4(4'd2, 4'd2, 1'b0, lat);
    total++;
    if ({sum4, cout4, ovf4} !== {4'd4, 1'b0, 1'b0} || lat !== 5)
      $display("FAIL post_reset_2_2 got sum=%0d c=%b v=%b lat=%0d want 4 0 0 5", sum4, cout4, ovf4, lat);
    else passed++;
  endtask

  task automatic test_width8();
    int lat;
    int ia, ib, bb, full;
    logic [7:0] ea, eb, es;
    logic ec, ev;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 20; i++) begin
        case (i)
          0: begin ia = 0;   ib = 0;   end
          1: begin ia = 255; ib = 255; end
          2: begin ia = 128; ib = 1;   end
          3: begin ia = 127; ib = 1;   end
          default: begin ia = (i * 37 + 5) % 256; ib = (i * 91 + 200) % 256; end
        endcase
        ea = ia[7:0];
        eb = ib[7:0];
        bb = (m == 1) ? (255 - ib) : ib;
        full = ia + bb + m;
        es = full[7:0];
        ec = full[8];
        ev = (ea[7] == bb[7]) && (es[7] != ea[7]);
        op8(ea, eb, m[0], lat);
        total++;
        if ({sum8, cout8, ovf8} !== {es, ec, ev} || lat !== 9)
          $display("FAIL w8_%s a=%0d b=%0d got sum=%0d c=%b v=%b lat=%0d want %0d %b %b 9",
                   (m == 1) ? "sub" : "add", ia, ib, sum8, cout8, ovf8, lat, es, ec, ev);
        else passed++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_async_reset();
    test_width8();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout passed=%0d total=%0d", passed, total);
    $fatal(1);
  end

endmodule
